// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// Segment patterns are active-low, bit order gfedcba.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low seven-segment pattern (gfedcba).
// Non-decimal codes show blank.
module bcd_to_7seg
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer driving HEX1:HEX0 (active-low).
// Optional macro COUNTDOWN_BLINK_EN blanks the display on alternate ticks while DONE.
//
// Handshake: tick, load and start are single-cycle strobes with no back-pressure;
// each is sampled on the rising clock edge and acts at most once.
module bcd_countdown
  import countdown_pkg::*;
#(
  parameter logic [3:0] DEFAULT_TENS  = 4'd3,
  parameter logic [3:0] DEFAULT_UNITS = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic [1:0] state_dbg
);

  state_t     state, state_nxt;
  logic [3:0] tens_nxt, units_nxt;
  logic       done_nxt;
  logic [6:0] seg1, seg0;

  // State and count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tens       <= DEFAULT_TENS;
      units      <= DEFAULT_UNITS;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      tens       <= tens_nxt;
      units      <= units_nxt;
      done_pulse <= done_nxt;
    end
  end

  // Next state and count; load beats start, start beats tick
  always_comb begin
    state_nxt = state;
    tens_nxt  = tens;
    units_nxt = units;
    if (load) begin
      state_nxt = IDLE;
      tens_nxt  = bcd_clamp(preset_tens);
      units_nxt = bcd_clamp(preset_units);
    end else begin
      case (state)
        IDLE: begin
          if (start)
            state_nxt = (tens == 4'd0 && units == 4'd0) ? DONE : RUN;
        end
        RUN: begin
          if (start) begin
            state_nxt = PAUSE;
          end else if (tick && !(tens == 4'd0 && units == 4'd0)) begin
            if (units != 4'd0) begin
              units_nxt = units - 4'd1;
            end else begin
              units_nxt = 4'd9;
              tens_nxt  = tens - 4'd1;
            end
            if (tens == 4'd0 && units == 4'd1)
              state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (start)
            state_nxt = RUN;
        end
        default: state_nxt = state;
      endcase
    end
    done_nxt = (state_nxt == DONE) && (state != DONE);
  end

  bcd_to_7seg u_seg_tens  (.digit(tens),  .seg(seg1));
  bcd_to_7seg u_seg_units (.digit(units), .seg(seg0));

`ifdef COUNTDOWN_BLINK_EN
  logic blink, blink_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink <= 1'b0;
    else       blink <= blink_nxt;
  end

  // Phase only runs while DONE; any other state (and DONE entry) forces visible
  always_comb begin
    blink_nxt = 1'b0;
    if (!load && state == DONE && state_nxt == DONE)
      blink_nxt = tick ? ~blink : blink;
  end
`else
  logic blink;
  assign blink = 1'b0;
`endif

  // Outputs
  always_comb begin
    running   = (state == RUN);
    expired   = (state == DONE);
    state_dbg = state;
    hex1      = blink ? SEG_BLANK : seg1;
    hex0      = blink ? SEG_BLANK : seg0;
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Table-driven bench for bcd_countdown plus hand sequences for async reset.
// Expected values are hand-computed digits; hex is derived from a local pattern table.
module tb_bcd_countdown;
  import countdown_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0;
  logic [3:0] preset_tens = 4'd0, preset_units = 4'd0;
  logic [3:0] tens, units;
  logic       running, expired, done_pulse;
  logic [6:0] hex1, hex0;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  bcd_countdown dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start),
    .preset_tens(preset_tens), .preset_units(preset_units),
    .tens(tens), .units(units), .running(running), .expired(expired),
    .done_pulse(done_pulse), .hex1(hex1), .hex0(hex0), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld, st, tk;
    logic [3:0] pt, pu;
    logic [3:0] et, eu;
    state_t     es;
    logic       edp;
    logic       eblank;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic add(input logic ld, st, tk, input logic [3:0] pt, pu,
                     input logic [3:0] et, eu, input state_t es,
                     input logic edp, eblank);
    vec_t v;
    v.ld = ld; v.st = st; v.tk = tk; v.pt = pt; v.pu = pu;
    v.et = et; v.eu = eu; v.es = es; v.edp = edp; v.eblank = eblank;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  // Driver: strobe inputs for exactly one rising edge, sample 1 time unit after it
  task automatic apply(input logic l, s, t, input logic [3:0] a, b);
    @(negedge clk);
    load = l; start = s; tick = t; preset_tens = a; preset_units = b;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; tick = 1'b0;
  endtask

  task automatic check_all(input int idx, input logic [3:0] et, eu, input state_t es,
                           input logic edp, eblank);
    logic blank;
    blank = BLINK_ON && eblank;
    chk("tens",       idx, {4'd0, tens},      {4'd0, et});
    chk("units",      idx, {4'd0, units},     {4'd0, eu});
    chk("state",      idx, {6'd0, state_dbg}, {6'd0, es});
    chk("running",    idx, {7'd0, running},   {7'd0, es == RUN});
    chk("expired",    idx, {7'd0, expired},   {7'd0, es == DONE});
    chk("done_pulse", idx, {7'd0, done_pulse}, {7'd0, edp});
    chk("hex1",       idx, {1'b0, hex1}, {1'b0, blank ? 7'h7F : seg_of(et)});
    chk("hex0",       idx, {1'b0, hex0}, {1'b0, blank ? 7'h7F : seg_of(eu)});
  endtask

  initial begin
    //  ld st tk  pt  pu   et  eu  state  dp blank
    add(0, 0, 0, 0, 0,   3, 0, IDLE,  0, 0);  // hold defaults
    add(1, 0, 0, 1, 2,   1, 2, IDLE,  0, 0);  // load 12
    add(0, 0, 1, 0, 0,   1, 2, IDLE,  0, 0);  // tick ignored in IDLE
    add(1, 0, 0, 1, 0,   1, 0, IDLE,  0, 0);  // load 10
    add(0, 1, 0, 0, 0,   1, 0, RUN,   0, 0);
    add(0, 0, 1, 0, 0,   0, 9, RUN,   0, 0);  // borrow from tens
    for (int i = 8; i >= 1; i--)
      add(0, 0, 1, 0, 0, 0, 4'(i), RUN, 0, 0);
    add(0, 0, 1, 0, 0,   0, 0, DONE,  1, 0);  // 01 -> 00 with done_pulse
    add(0, 0, 0, 0, 0,   0, 0, DONE,  0, 0);  // pulse lasts one cycle
    add(0, 0, 1, 0, 0,   0, 0, DONE,  0, 1);  // no underflow; blink phase 1
    add(0, 0, 1, 0, 0,   0, 0, DONE,  0, 0);  // blink phase back to 0
    add(0, 1, 0, 0, 0,   0, 0, DONE,  0, 0);  // start ignored in DONE
    add(1, 0, 0, 2, 5,   2, 5, IDLE,  0, 0);
    add(0, 1, 0, 0, 0,   2, 5, RUN,   0, 0);
    add(0, 1, 1, 0, 0,   2, 5, PAUSE, 0, 0);  // start wins over tick
    for (int i = 0; i < 3; i++)
      add(0, 0, 1, 0, 0, 2, 5, PAUSE, 0, 0);
    add(0, 1, 1, 0, 0,   2, 5, RUN,   0, 0);  // resume, tick ignored
    add(0, 0, 1, 0, 0,   2, 4, RUN,   0, 0);
    add(1, 1, 1, 12, 15, 9, 9, IDLE,  0, 0);  // load wins, both digits clamp
    add(0, 1, 0, 0, 0,   9, 9, RUN,   0, 0);
    add(0, 0, 1, 0, 0,   9, 8, RUN,   0, 0);
    add(1, 1, 1, 4, 7,   4, 7, IDLE,  0, 0);  // load in RUN, no decrement
    add(1, 0, 0, 0, 0,   0, 0, IDLE,  0, 0);
    add(0, 1, 0, 0, 0,   0, 0, DONE,  1, 0);  // start at 00 goes straight to DONE
    add(0, 0, 1, 0, 0,   0, 0, DONE,  0, 1);
    add(0, 1, 0, 0, 0,   0, 0, DONE,  0, 1);  // start keeps phase
    add(1, 0, 0, 0, 5,   0, 5, IDLE,  0, 0);  // load clears expired and blink
    add(0, 1, 0, 0, 0,   0, 5, RUN,   0, 0);
    add(0, 0, 1, 0, 0,   0, 4, RUN,   0, 0);

    // Reset phase
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 4'd3, 4'd0, IDLE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].ld, vecs[i].st, vecs[i].tk, vecs[i].pt, vecs[i].pu);
      check_all(i, vecs[i].et, vecs[i].eu, vecs[i].es, vecs[i].edp, vecs[i].eblank);
    end

    // Asynchronous reset mid-RUN (count 04), between edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all(100, 4'd3, 4'd0, IDLE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check_all(101, 4'd3, 4'd0, IDLE, 1'b0, 1'b0);

    // Async reset while DONE with pulse high
    apply(1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check_all(102, 4'd0, 4'd0, DONE, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all(103, 4'd3, 4'd0, IDLE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
